// File: rtl/wincmp_pkg.sv
// rtl/wincmp_pkg.sv - shared types and build options for the window comparator (hysteresis via WINCMP_HYST_EN)
package wincmp_pkg;

    typedef enum logic [1:0] {ST_UNPRIMED, ST_OUTSIDE, ST_INSIDE} wincmp_state_t;

    localparam int WINCMP_WIDTH = 10;

`ifdef WINCMP_HYST_EN
    localparam bit WINCMP_HYST_ON = 1'b1;
`else
    localparam bit WINCMP_HYST_ON = 1'b0;
`endif

endpackage

// File: rtl/window_comparator_ch.sv
// rtl/window_comparator_ch.sv - one channel: raw compares, crossing FSM, pulses and sticky hit
module window_comparator_ch
    import wincmp_pkg::*;
#(
    parameter int          WIDTH = WINCMP_WIDTH,
    parameter int unsigned HYST  = 2
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic             clear,
    output logic             gt,
    output logic             lt,
    output logic             is_inside,
    output logic             enter,
    output logic             exit,
    output logic             hit_sticky,
    output logic             hit_next
);

    // Exit margin is zero unless hysteresis is compiled in; the extra bit keeps hi + margin from wrapping.
    localparam logic [WIDTH:0] MARGIN = WINCMP_HYST_ON ? (WIDTH+1)'(HYST) : '0;

    wincmp_state_t state, state_nxt;
    logic          raw_gt, raw_lt, in_win, leave;
    logic          enter_nxt, exit_nxt;
    logic [WIDTH:0] a_x, lo_x, hi_x;

    always_comb begin
        a_x    = {1'b0, a};
        lo_x   = {1'b0, lo};
        hi_x   = {1'b0, hi};
        raw_gt = a > hi;
        raw_lt = a < lo;
        in_win = !raw_gt && !raw_lt;
        // An empty window must never keep a channel inside, even within the margin.
        leave  = (a_x > hi_x + MARGIN) || (a_x + MARGIN < lo_x) || (lo > hi);
    end

    always_comb begin
        state_nxt = state;
        enter_nxt = 1'b0;
        exit_nxt  = 1'b0;
        if (in_valid) begin
            case (state)
                ST_OUTSIDE: begin
                    if (in_win) begin
                        state_nxt = ST_INSIDE;
                        enter_nxt = 1'b1;
                    end
                end
                ST_INSIDE: begin
                    if (leave) begin
                        state_nxt = ST_OUTSIDE;
                        exit_nxt  = 1'b1;
                    end
                end
                default: state_nxt = in_win ? ST_INSIDE : ST_OUTSIDE;
            endcase
        end
    end

    assign hit_next = enter_nxt | (hit_sticky & ~clear);

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state      <= ST_UNPRIMED;
            gt         <= 1'b0;
            lt         <= 1'b0;
            is_inside  <= 1'b0;
            enter      <= 1'b0;
            exit       <= 1'b0;
            hit_sticky <= 1'b0;
        end else begin
            state      <= state_nxt;
            enter      <= enter_nxt;
            exit       <= exit_nxt;
            hit_sticky <= hit_next;
            if (in_valid) begin
                gt        <= raw_gt;
                lt        <= raw_lt;
                is_inside <= (state_nxt == ST_INSIDE);
            end
        end
    end

endmodule

// File: rtl/window_comparator.sv
// rtl/window_comparator.sv - multi-channel registered window comparator (hysteresis via WINCMP_HYST_EN)
module window_comparator
    import wincmp_pkg::*;
#(
    parameter int          WIDTH    = WINCMP_WIDTH,
    parameter int          CHANNELS = 4,
    parameter int unsigned HYST     = 2
) (
    input  logic                      clk,
    input  logic                      Reset,
    input  logic                      in_valid,
    input  logic [CHANNELS*WIDTH-1:0] a,
    input  logic [WIDTH-1:0]          lo,
    input  logic [WIDTH-1:0]          hi,
    input  logic                      clear,
    output logic                      out_valid,
    output logic [CHANNELS-1:0]       gt,
    output logic [CHANNELS-1:0]       lt,
    output logic [CHANNELS-1:0]       is_inside,
    output logic [CHANNELS-1:0]       enter,
    output logic [CHANNELS-1:0]       exit,
    output logic [CHANNELS-1:0]       hit_sticky,
    output logic                      any_hit
);

    logic [CHANNELS-1:0] hit_next;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        window_comparator_ch #(
            .WIDTH (WIDTH),
            .HYST  (HYST)
        ) u_ch (
            .clk        (clk),
            .Reset      (Reset),
            .in_valid   (in_valid),
            .a          (a[i*WIDTH +: WIDTH]),
            .lo         (lo),
            .hi         (hi),
            .clear      (clear),
            .gt         (gt[i]),
            .lt         (lt[i]),
            .is_inside  (is_inside[i]),
            .enter      (enter[i]),
            .exit       (exit[i]),
            .hit_sticky (hit_sticky[i]),
            .hit_next   (hit_next[i])
        );
    end

    // any_hit is built from the next sticky values so it lines up with hit_sticky.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            out_valid <= 1'b0;
            any_hit   <= 1'b0;
        end else begin
            out_valid <= in_valid;
            any_hit   <= |hit_next;
        end
    end

endmodule

// File: tb/tb_window_comparator.sv
// tb/tb_window_comparator.sv - scoreboard bench for window_comparator (expectations follow WINCMP_HYST_EN)
module tb_window_comparator;
    localparam int W = 10;
    localparam int C = 4;
`ifdef WINCMP_HYST_EN
    localparam bit HYST_ON = 1'b1;
`else
    localparam bit HYST_ON = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           Reset = 1'b1;
    logic           in_valid = 1'b0;
    logic [C*W-1:0] a = '0;
    logic [W-1:0]   lo = '0;
    logic [W-1:0]   hi = '0;
    logic           clear = 1'b0;
    logic           out_valid;
    logic [C-1:0]   gt, lt, is_inside, enter, exit, hit_sticky;
    logic           any_hit;

    int total_cnt = 0;
    int pass_cnt  = 0;
    logic [24:0] exp_q[$];

    always #5 clk = ~clk;

    window_comparator #(.WIDTH(W), .CHANNELS(C), .HYST(2)) dut (
        .clk(clk), .Reset(Reset), .in_valid(in_valid), .a(a), .lo(lo), .hi(hi),
        .clear(clear), .out_valid(out_valid), .gt(gt), .lt(lt), .is_inside(is_inside),
        .enter(enter), .exit(exit), .hit_sticky(hit_sticky), .any_hit(any_hit)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total_cnt++;
        if (got === want) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, got, want);
    endtask

    function automatic logic [24:0] outs();
        return {gt, lt, is_inside, enter, exit, hit_sticky, any_hit};
    endfunction

    // Drive one valid sample and queue its expected result; returns on the next falling edge.
    task automatic send(input int a0, input int a1, input int a2, input int a3,
                        input int lo_v, input int hi_v, input logic clr,
                        input logic [3:0] e_gt, input logic [3:0] e_lt, input logic [3:0] e_in,
                        input logic [3:0] e_en, input logic [3:0] e_ex, input logic [3:0] e_hit,
                        input logic e_any);
        in_valid = 1'b1;
        a        = {W'(a3), W'(a2), W'(a1), W'(a0)};
        lo       = W'(lo_v);
        hi       = W'(hi_v);
        clear    = clr;
        exp_q.push_back({e_gt, e_lt, e_in, e_en, e_ex, e_hit, e_any});
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 32'(outs()), 32'hFFFF_FFFF);
            end else begin
                logic [24:0] e;
                e = exp_q.pop_front();
                check("sample_outputs", 32'(outs()), 32'(e));
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        check("reset_state", 32'({out_valid, outs()}), 32'd0);
        Reset = 1'b0;

        // entry/exit on ch0, boundaries on ch1..ch3
        send( 50, 100,  50, 250, 100, 200, 0, 4'b1000, 4'b0101, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 0);
        send(150, 200,  50, 201, 100, 200, 0, 4'b1000, 4'b0100, 4'b0011, 4'b0001, 4'b0000, 4'b0001, 1);
        send(150,  90,  99, 201, 100, 200, 0, 4'b1000, 4'b0110, 4'b0001, 4'b0000, 4'b0010, 4'b0001, 1);
        send(250,  90,  99, 201, 100, 200, 0, 4'b1001, 4'b0110, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 1);
        // sticky priority: clear coincides with ch2 entry, then clear alone
        send(250,  90, 150, 201, 100, 200, 1, 4'b1001, 4'b0010, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 1);
        send(250,  90, 150, 201, 100, 200, 1, 4'b1001, 4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 0);
        // empty window lo > hi
        send(250,  90, 150, 201, 300, 200, 0, 4'b1001, 4'b1111, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 0);
        send(300, 200, 250,   0, 300, 200, 0, 4'b0101, 4'b1110, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
        send(150,  50, 150,  50, 100, 200, 0, 4'b0000, 4'b1010, 4'b0101, 4'b0101, 4'b0000, 4'b0101, 1);

        // valid gap: inputs wander, outputs must hold with no pulses
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b0;
            clear    = 1'b0;
            a        = {W'(250 + i), W'(150), W'(150), W'(50 + i)};
            @(negedge clk);
            check("gap_hold", 32'({out_valid, outs()}),
                  32'({1'b0, 4'b0000, 4'b1010, 4'b0101, 4'b0000, 4'b0000, 4'b0101, 1'b1}));
        end

        send( 50, 150, 150,  50, 100, 200, 0, 4'b0000, 4'b1001, 4'b0110, 4'b0010, 4'b0001, 4'b0111, 1);
        // hysteresis margin of 2 on ch1
        send( 50, 202, 150,  50, 100, 200, 0, 4'b0010, 4'b1001, HYST_ON ? 4'b0110 : 4'b0100,
              4'b0000, HYST_ON ? 4'b0000 : 4'b0010, 4'b0111, 1);
        send( 50, 203, 150,  50, 100, 200, 0, 4'b0010, 4'b1001, 4'b0100,
              4'b0000, HYST_ON ? 4'b0010 : 4'b0000, 4'b0111, 1);
        send( 50, 150, 150,  50, 100, 1023, 0, 4'b0000, 4'b1001, 4'b0110, 4'b0010, 4'b0000, 4'b0111, 1);
        send( 50, 1023, 150, 50, 100, 1023, 0, 4'b0000, 4'b1001, 4'b0110, 4'b0000, 4'b0000, 4'b0111, 1);
        // build hit_sticky = 1010 ahead of a mid-run reset
        send( 50,  50,  50,  50, 100, 200, 1, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0110, 4'b0000, 0);
        send( 50, 150,  50, 150, 100, 200, 0, 4'b0000, 4'b0101, 4'b1010, 4'b1010, 4'b0000, 4'b1010, 1);

        #2;
        Reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        check("reset_async", 32'({out_valid, outs()}), 32'd0);
        @(negedge clk);
        Reset = 1'b0;
        send(150,  50,  50, 250, 100, 200, 0, 4'b1000, 4'b0110, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0);

        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
